// File: rtl/ctrl_decode_stage_if.sv
// ID->EX control interface of the Buraq-mini decode stage.
// The master side is fetch/ID (and the EX consumers); the slave side is the decode stage.
interface ctrl_decode_stage_if #(
  parameter int CNT_W = 32
) ();
  logic             id_valid_i;
  logic [31:0]      id_instr_i;
  logic             flush_i;
  logic             stall_o;
  logic             ex_valid_o;
  logic             ex_branch_op_o;
  logic             ex_mem_read_o;
  logic             ex_mem_to_reg_o;
  logic             ex_mem_write_o;
  logic             ex_reg_write_en_o;
  logic             ex_operand_b_sel_o;
  logic [1:0]       ex_next_pc_sel_o;
  logic [1:0]       ex_operand_a_sel_o;
  logic [1:0]       ex_extend_sel_o;
  logic [2:0]       ex_alu_op_o;
  logic             ex_md_op_o;
  logic             ex_illegal_o;
  logic             md_start_o;
  logic             md_wb_o;
  logic [CNT_W-1:0] retire_cnt_o;

  modport master (
    output id_valid_i, id_instr_i, flush_i,
    input  stall_o, ex_valid_o, ex_branch_op_o, ex_mem_read_o, ex_mem_to_reg_o,
           ex_mem_write_o, ex_reg_write_en_o, ex_operand_b_sel_o, ex_next_pc_sel_o,
           ex_operand_a_sel_o, ex_extend_sel_o, ex_alu_op_o, ex_md_op_o, ex_illegal_o,
           md_start_o, md_wb_o, retire_cnt_o
  );

  modport slave (
    input  id_valid_i, id_instr_i, flush_i,
    output stall_o, ex_valid_o, ex_branch_op_o, ex_mem_read_o, ex_mem_to_reg_o,
           ex_mem_write_o, ex_reg_write_en_o, ex_operand_b_sel_o, ex_next_pc_sel_o,
           ex_operand_a_sel_o, ex_extend_sel_o, ex_alu_op_o, ex_md_op_o, ex_illegal_o,
           md_start_o, md_wb_o, retire_cnt_o
  );
endinterface

// File: rtl/ctrl_decode_stage.sv
// RV32IM decode stage: registers the EX control bundle, flags illegal encodings,
// sequences multi-cycle MUL/DIV with a fetch stall and counts retired instructions.
module ctrl_decode_stage #(
  parameter bit ENABLE_M    = 1'b1,
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 33,
  parameter int CNT_W       = 32
) (
  input logic                clk,
  input logic                rst_n,
  ctrl_decode_stage_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       mdOp;
    logic       branchOp;
    logic       memRead;
    logic       memToReg;
    logic       memWrite;
    logic       regWriteEn;
    logic       operandBSel;
    logic [1:0] nextPcSel;
    logic [1:0] operandASel;
    logic [1:0] extendSel;
    logic [2:0] aluOp;
  } bundle_t;

  localparam logic [7:0] MUL_CNT = 8'(MUL_LATENCY - 1);
  localparam logic [7:0] DIV_CNT = 8'(DIV_LATENCY - 1);

  state_t           state_q, state_d;
  logic [7:0]       latCnt_q, latCnt_d;
  bundle_t          bundle_q, bundle_d, dec;
  logic             mdStart_q, mdStart_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             illegal, loadId, busy, mdWb, unusedInstrBits;

  logic [6:0] opcode, funct7;
  assign opcode = bus.id_instr_i[6:0];
  assign funct7 = bus.id_instr_i[31:25];
  assign unusedInstrBits = ^{bus.id_instr_i[24:15], bus.id_instr_i[13:7]};

  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    illegal     = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec.regWriteEn = 1'b1;
        if (funct7 == 7'b0000001) begin
          if (ENABLE_M) dec.mdOp = 1'b1;
          else          illegal  = 1'b1;
        end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
          illegal = 1'b1;
        end
      end
      7'b0010011: begin dec.aluOp = 3'b001; dec.operandBSel = 1'b1; dec.regWriteEn = 1'b1; end
      7'b0000011: begin
        dec.aluOp = 3'b100; dec.operandBSel = 1'b1; dec.regWriteEn = 1'b1;
        dec.memRead = 1'b1; dec.memToReg = 1'b1;
      end
      7'b0100011: begin
        dec.aluOp = 3'b101; dec.operandBSel = 1'b1; dec.memWrite = 1'b1; dec.extendSel = 2'b01;
      end
      7'b1100011: begin dec.aluOp = 3'b010; dec.branchOp = 1'b1; dec.nextPcSel = 2'b01; end
      7'b1100111: begin
        dec.aluOp = 3'b011; dec.operandASel = 2'b10; dec.operandBSel = 1'b1;
        dec.regWriteEn = 1'b1; dec.nextPcSel = 2'b11;
      end
      7'b1101111: begin
        dec.aluOp = 3'b011; dec.operandASel = 2'b10; dec.regWriteEn = 1'b1; dec.nextPcSel = 2'b10;
      end
      7'b0010111: begin
        dec.aluOp = 3'b110; dec.operandASel = 2'b01; dec.operandBSel = 1'b1;
        dec.extendSel = 2'b10; dec.regWriteEn = 1'b1;
      end
      7'b0110111: begin
        dec.aluOp = 3'b110; dec.operandASel = 2'b11; dec.operandBSel = 1'b1;
        dec.extendSel = 2'b10; dec.regWriteEn = 1'b1;
      end
      7'b0001111: ;
      default:    illegal = 1'b1;
    endcase
    if (bus.id_instr_i[1:0] != 2'b11) illegal = 1'b1;
    // An illegal op still reaches EX so the trap can be taken, but must not change state.
    if (illegal) begin
      dec.regWriteEn = 1'b0;
      dec.memWrite   = 1'b0;
      dec.memRead    = 1'b0;
      dec.branchOp   = 1'b0;
      dec.nextPcSel  = 2'b00;
      dec.mdOp       = 1'b0;
    end
    dec.illegal = illegal;
  end

  assign busy = (state_q == BUSY);
  assign mdWb = busy && (latCnt_q == 8'd0);

  // The last busy cycle doubles as an IDLE cycle, so a queued op enters EX on the exit edge.
  always_comb begin
    state_d   = state_q;
    latCnt_d  = latCnt_q;
    bundle_d  = bundle_q;
    mdStart_d = 1'b0;
    loadId    = 1'b0;
    case (state_q)
      IDLE: loadId = 1'b1;
      BUSY: begin
        if (latCnt_q == 8'd0) begin
          state_d = IDLE;
          loadId  = 1'b1;
        end else begin
          latCnt_d = latCnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (loadId) begin
      if (bus.flush_i || !bus.id_valid_i) begin
        bundle_d = '0;
      end else begin
        bundle_d = dec;
        if (dec.mdOp) begin
          state_d   = BUSY;
          mdStart_d = 1'b1;
          latCnt_d  = bus.id_instr_i[14] ? DIV_CNT : MUL_CNT;
        end
      end
    end
  end

  // A MUL/DIV counts on its write-back cycle: its bundle may be replaced on the exit edge.
  always_comb begin
    retire_d = retire_q;
    if (bundle_q.valid && !bundle_q.illegal && (!busy || mdWb)) retire_d = retire_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      latCnt_q  <= '0;
      bundle_q  <= '0;
      mdStart_q <= 1'b0;
      retire_q  <= '0;
    end else begin
      state_q   <= state_d;
      latCnt_q  <= latCnt_d;
      bundle_q  <= bundle_d;
      mdStart_q <= mdStart_d;
      retire_q  <= retire_d;
    end
  end

  assign bus.stall_o            = busy;
  assign bus.md_wb_o            = mdWb;
  assign bus.md_start_o         = mdStart_q;
  assign bus.retire_cnt_o       = retire_q;
  assign bus.ex_valid_o         = bundle_q.valid;
  assign bus.ex_illegal_o       = bundle_q.illegal;
  assign bus.ex_md_op_o         = bundle_q.mdOp;
  assign bus.ex_branch_op_o     = bundle_q.branchOp;
  assign bus.ex_mem_read_o      = bundle_q.memRead;
  assign bus.ex_mem_to_reg_o    = bundle_q.memToReg;
  assign bus.ex_mem_write_o     = bundle_q.memWrite;
  assign bus.ex_reg_write_en_o  = bundle_q.regWriteEn;
  assign bus.ex_operand_b_sel_o = bundle_q.operandBSel;
  assign bus.ex_next_pc_sel_o   = bundle_q.nextPcSel;
  assign bus.ex_operand_a_sel_o = bundle_q.operandASel;
  assign bus.ex_extend_sel_o    = bundle_q.extendSel;
  assign bus.ex_alu_op_o        = bundle_q.aluOp;

endmodule
